mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data RAM between two requesters: the CPU's multicycle memory path (fetch/load/store) and an external loader/debug port.
- Sits between `datapath_main`'s memory request signals, the external port, and the RAM macro.
- Sequences each access as a 3-state transaction: latch, issue, respond.
- Arbitrates with round-robin fairness plus an external lock for burst program loading.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/rr_arb2.sv | 36 +++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified RAM port arbiter: size defaults,
// transaction state encoding and requester ids.
package mem_port_arbiter_pkg;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_RAM_SIZE  = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_EXT = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with an ext-only lock. Bit 0 of req/grant is
// the CPU, bit 1 the external port; grant is one-hot or zero.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (lock) begin
      grant[GRANT_EXT] = req[GRANT_EXT];
    end else if (&req) begin
      grant = (last_grant == GRANT_EXT) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Only a grant that is actually taken moves the fairness pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_EXT;
    end else if (advance && (|grant)) begin
      last_grant <= grant[GRANT_EXT];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported instruction/data RAM between the CPU memory path
// and the external loader port; each access is latch -> issue -> respond.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int RAM_SIZE  = DEF_RAM_SIZE,
  localparam int ADDR_BITS = $clog2(RAM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [WORD_SIZE-1:0] ext_addr,
  input  logic [WORD_SIZE-1:0] ext_wdata,
  output logic [WORD_SIZE-1:0] ext_rdata,
  output logic                 ext_ack,
  output logic                 ext_err,
  input  logic                 ext_lock,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 busy
);

  localparam logic [WORD_SIZE:0] ADDR_LIMIT = (WORD_SIZE+1)'(RAM_SIZE * 4);

  // Handshake: a requester raises req with we/addr/wdata stable and holds it
  // until its one-cycle ack; req still high in the IDLE after ack is a new request.
  arb_state_t             state, state_next;
  logic [1:0]             grant;
  logic                   grant_id_q;
  logic                   we_q;
  logic [WORD_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic                   oor, mis;
  logic [WORD_SIZE-1:0]   resp_rdata;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({ext_req, cpu_req}),
    .lock    (ext_lock),
    .advance (state == IDLE),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id_q <= GRANT_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && (|grant)) begin
        grant_id_q <= grant[GRANT_EXT];
        we_q       <= grant[GRANT_EXT] ? ext_we    : cpu_we;
        addr_q     <= grant[GRANT_EXT] ? ext_addr  : cpu_addr;
        wdata_q    <= grant[GRANT_EXT] ? ext_wdata : cpu_wdata;
      end
    end
  end

  // Misaligned accesses still go to the RAM, word-aligned; only oor suppresses them.
  assign oor        = ({1'b0, addr_q} >= ADDR_LIMIT);
  assign mis        = |addr_q[1:0];
  assign ram_addr   = addr_q[ADDR_BITS+1:2];
  assign ram_wdata  = wdata_q;
  assign resp_rdata = (we_q || oor) ? '0 : ram_rdata;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    cpu_ack    = 1'b0;
    cpu_err    = 1'b0;
    cpu_rdata  = '0;
    ext_ack    = 1'b0;
    ext_err    = 1'b0;
    ext_rdata  = '0;
    case (state)
      IDLE: begin
        if (|grant) state_next = ISSUE;
      end
      ISSUE: begin
        ram_en     = !oor;
        ram_we     = we_q && !oor;
        state_next = DONE;
      end
      DONE: begin
        if (grant_id_q == GRANT_EXT) begin
          ext_ack   = 1'b1;
          ext_err   = oor | mis;
          ext_rdata = resp_rdata;
        end else begin
          cpu_ack   = 1'b1;
          cpu_err   = oor | mis;
          cpu_rdata = resp_rdata;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM and
// an expected-response queue checked on every ack.
module tb_mem_port_arbiter;

  localparam int WS = 32;
  localparam int AB = 10;
  localparam int W  = WS + 2;   // {is_ext, err, rdata}

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [WS-1:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [WS-1:0] cpu_rdata, ext_rdata, ram_wdata, ram_rdata;
  logic          cpu_ack, cpu_err, ext_ack, ext_err;
  logic          ram_en, ram_we, busy;
  logic [AB-1:0] ram_addr;

  logic [WS-1:0] mem [0:1023];
  logic          pl_en;
  logic [AB-1:0] pl_addr;
  logic [WS-1:0] pl_data;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .ext_err   (ext_err),
    .ext_lock  (ext_lock),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // Behavioural RAM: synchronous read, plus a preload port used under reset.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
    if (port) begin
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    exp_q.push_back({port, err, rdata});
  endtask

  task automatic drop_req(input logic port);
    if (port) ext_req = 1'b0;
    else      cpu_req = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    logic         gext;
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e    = exp_q.pop_front();
    gext = e[W-1];
    chk({tag, "_port"}, {30'b0, ext_ack, cpu_ack}, gext ? 32'd2 : 32'd1);
    chk({tag, "_err"}, {31'b0, gext ? ext_err : cpu_err}, {31'b0, e[W-2]});
    chk({tag, "_rdata"}, gext ? ext_rdata : cpu_rdata, e[WS-1:0]);
    chk({tag, "_idle_port"}, gext ? (cpu_rdata | {31'b0, cpu_err}) : (ext_rdata | {31'b0, ext_err}), 32'd0);
  endtask

  // Advances at least one cycle, then waits (bounded) for the next ack.
  task automatic wait_ack(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(cpu_ack || ext_ack) && lat < 20);
    if (cpu_ack || ext_ack) sb_check(tag);
    else chk({tag, "_timeout"}, {31'b0, cpu_ack | ext_ack}, 32'd1);
  endtask

  task automatic do_access(input string tag, input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
    int lat;
    start_req(port, we, addr, wdata, err, rdata);
    wait_ack(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    drop_req(port);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic ack_seen;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    ext_lock = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    @(negedge clk);
    chk("rst_flags", {25'b0, cpu_ack, cpu_err, ext_ack, ext_err, ram_en, ram_we, busy}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_ext_rdata", ext_rdata, 32'd0);
    pl_en = 1'b1; pl_addr = 10'd4; pl_data = 32'hDEADBEEF;
    @(negedge clk);
    pl_addr = 10'd2; pl_data = 32'h0BADF00D;
    @(negedge clk);
    pl_en = 1'b0;
    rst = 1'b0;

    // Basic CPU read with cycle-accurate timing.
    start_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_ram_en", {31'b0, ram_en}, 32'd1);
    chk("t1_ram_addr", 32'(ram_addr), 32'd4);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wait_ack("t1", lat);
    chk("t1_latency", 32'(lat), 32'd1);
    drop_req(1'b0);
    @(negedge clk);
    chk("t1_busy_low", {31'b0, busy}, 32'd0);

    // Simultaneous writes straight out of reset: CPU first, then ext.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_req(1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 32'h0);
    start_req(1'b1, 1'b1, 32'h4, 32'h22222222, 1'b0, 32'h0);
    wait_ack("t2_cpu", lat);
    chk("t2_cpu_ack_cycle", 32'(lat), 32'd2);
    drop_req(1'b0);
    wait_ack("t2_ext", lat);
    chk("t2_ext_ack_cycle", 32'(lat), 32'd3);
    drop_req(1'b1);
    @(negedge clk);
    do_access("t2_rd0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h11111111);
    do_access("t2_rd1", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h22222222);

    // Continuous requests alternate, starting with CPU (ext was last).
    start_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    start_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h22222222);
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b1, 1'b0, 32'h22222222});
    for (int i = 0; i < 4; i++) wait_ack("t3_rr", lat);
    drop_req(1'b0);
    drop_req(1'b1);
    @(negedge clk);

    // Lock: only ext served; releasing it lets the CPU in next.
    ext_lock = 1'b1;
    start_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    exp_q.pop_back();
    start_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h22222222);
    exp_q.push_back({1'b1, 1'b0, 32'h22222222});
    exp_q.push_back({1'b1, 1'b0, 32'h22222222});
    for (int i = 0; i < 3; i++) wait_ack("t4_lock", lat);
    ext_lock = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    wait_ack("t4_unlock", lat);
    drop_req(1'b0);
    drop_req(1'b1);
    @(negedge clk);

    // Out-of-range read never touches the RAM.
    start_req(1'b0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    chk("t5_oor_ram_en", {31'b0, ram_en}, 32'd0);
    wait_ack("t5_oor", lat);
    drop_req(1'b0);
    @(negedge clk);

    // Misaligned read is performed word-aligned and flagged.
    start_req(1'b0, 1'b0, 32'h6, 32'h0, 1'b1, 32'h22222222);
    @(negedge clk);
    chk("t5_mis_ram_addr", 32'(ram_addr), 32'd1);
    wait_ack("t5_mis", lat);
    drop_req(1'b0);
    @(negedge clk);

    // Reset during ISSUE of an ext write aborts it with no ack and no commit.
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h8; ext_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t6_pre_ram_we", {31'b0, ram_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_ram_we_drop", {29'b0, ram_we, ram_en, busy}, 32'd0);
    ext_req = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ack_seen = ack_seen | cpu_ack | ext_ack;
    end
    chk("t6_no_ack", {31'b0, ack_seen}, 32'd0);
    rst = 1'b0;
    start_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    start_req(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0BADF00D);
    wait_ack("t6_tie_cpu", lat);
    drop_req(1'b0);
    wait_ack("t6_word2", lat);
    drop_req(1'b1);
    @(negedge clk);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
